pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit for the single-cycle RISC-V core: holds PC, selects next PC
//  (sequential / branch / jalr), enforces instruction alignment and redirects to a trap vector.
//  Adds boot delay, stall, halt/resume and a retired-instruction counter.
//  Sits between the fetch memory (drives its address) and decode/ALU (supplies targets and conditions).
// PARAMETERS
//  XLEN          32       PC, target and counter width
//  RESET_VECTOR  32'h0    PC value loaded on reset
//  TRAP_VECTOR   32'h100  PC value loaded on a misaligned target
//  COMPRESSED    0        0: IALIGN=32 (PC[1:0] must be 0); 1: IALIGN=16 (PC[0] must be 0), 2-byte steps allowed
//  BOOT_DELAY    2        cycles held in BOOT after reset before fetch starts (0 = none)
// PORTS
//  clock         in   1     rising-edge clock
//  Reset         in   1     synchronous, active-low reset
//  Stall         in   1     hold PC this cycle (RUN only)
//  Branch        in   1     branch taken (ANDBranch)
//  BranchOffset  in   XLEN  byte offset, already shifted, sign-extended
//  Jalr          in   1     register-indirect jump
//  JalrBase      in   XLEN  rs1 value
//  JalrOffset    in   XLEN  sign-extended immediate
//  InstrLen16    in   1     current instruction is 16-bit (ignored when COMPRESSED=0)
//  Halt          in   1     enter HALT
//  Resume        in   1     leave HALT
//  PC            out  XLEN  current fetch address (registered)
//  PCPlus        out  XLEN  PC + step (link address, combinational)
//  Valid         out  1     PC is a valid fetch address this cycle
//  Misaligned    out  1     one-cycle pulse: trap taken on this edge
//  RetireCount   out  XLEN  instructions committed since reset
// BEHAVIOUR
//  - Reset==0 at posedge overrides everything, from any state: PC=RESET_VECTOR, state=BOOT
//    (RUN if BOOT_DELAY==0), boot counter=0, Misaligned=0, RetireCount=0.
//  - step = (COMPRESSED && InstrLen16) ? 2 : 4. All sums are modulo 2^XLEN, wrap silently.
//  - States: BOOT, RUN, HALT, TRAP. Valid=1 only in RUN. Outputs are decoded from the registered state.
//  - BOOT: PC held; counter increments each cycle; at counter==BOOT_DELAY-1, next state is RUN.
//  - RUN, priority per cycle: Halt > Stall > redirect/sequential.
//    Halt: PC held, next state HALT, no retire.
//    Stall: PC held, no retire.
//    Otherwise target = Jalr ? (JalrBase+JalrOffset) & ~1 : Branch ? PC+BranchOffset : PC+step
//    (Jalr wins over Branch). One instruction is retired (RetireCount+1).
//    Misaligned target (COMPRESSED=0: target[1]==1; COMPRESSED=1: target[0]==1):
//    PC=TRAP_VECTOR, Misaligned=1 for exactly that cycle, next state TRAP.
//    The faulting instruction still retires. Otherwise PC=target.
//  - TRAP: one cycle, Valid=0, PC held at TRAP_VECTOR, Misaligned=0, then RUN.
//  - HALT: PC held, Valid=0. Resume=1 gives RUN next cycle (Resume wins over Halt in HALT).
//    Stall is ignored outside RUN.
//  - Branch/Jalr/Stall are ignored outside RUN. RetireCount wraps at 2^XLEN.
//  - Sequential step of 4 with COMPRESSED=1 from a 2-aligned PC is legal (no trap).
// TESTING
//  1. Reset=0 for 2 cycles, then release; BOOT_DELAY=2 -> PC=0, Valid=0 for 2 cycles;
//     then Valid=1, PC=0,4,8 on successive cycles; RetireCount=3 after 3 RUN cycles.
//  2. PC=0x40, Branch=1, BranchOffset=0xFFFFFFF8 -> PC=0x38. Then Jalr=1 and Branch=1,
//     JalrBase=0x201, JalrOffset=0 -> PC=0x200 (Jalr priority, bit0 cleared).
//  3. COMPRESSED=0, PC=0x10, Branch=1, BranchOffset=6 -> PC=0x100, Misaligned=1 for one cycle;
//     next cycle TRAP (Valid=0); then RUN with PC=0x104 after one sequential step.
//  4. COMPRESSED=1, InstrLen16=1 from PC=0x20 -> 0x22; then BranchOffset=2 -> 0x24, no trap.
//  5. Stall=1 for 3 cycles at PC=0x80 -> PC and RetireCount frozen. Halt+Stall -> HALT;
//     Resume after 5 cycles -> RUN, PC still 0x80.
//  6. Reset=0 asserted mid-HALT and mid-TRAP -> next edge PC=RESET_VECTOR, RetireCount=0,
//     state BOOT. PC=0xFFFFFFFC sequential -> PC=0x0 wrap, no trap.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter unit: holds the fetch PC, picks the next PC (sequential,
// branch or jalr), traps misaligned targets to a fixed vector, and tracks
// boot delay, stall, halt/resume and retired instructions.
module pc_sequencer #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(256),
  parameter int               COMPRESSED   = 0,
  parameter int               BOOT_DELAY   = 2
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Branch,
  input  logic [XLEN-1:0] BranchOffset,
  input  logic            Jalr,
  input  logic [XLEN-1:0] JalrBase,
  input  logic [XLEN-1:0] JalrOffset,
  input  logic            InstrLen16,
  input  logic            Halt,
  input  logic            Resume,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus,
  output logic            Valid,
  output logic            Misaligned,
  output logic [XLEN-1:0] RetireCount
);

  // Boot counter only has to reach BOOT_DELAY-1; keep at least one bit.
  localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   ret_q, ret_d;

  logic [XLEN-1:0]   step;
  logic [XLEN-1:0]   jalr_sum;
  logic [XLEN-1:0]   target;
  logic              target_mis;

  // Next-PC candidate and its alignment check; jalr outranks branch.
  always_comb begin
    step       = ((COMPRESSED != 0) && InstrLen16) ? XLEN'(2) : XLEN'(4);
    jalr_sum   = JalrBase + JalrOffset;
    if (Jalr) begin
      target = jalr_sum & ~XLEN'(1);
    end else if (Branch) begin
      target = pc_q + BranchOffset;
    end else begin
      target = pc_q + step;
    end
    target_mis = (COMPRESSED != 0) ? target[0] : target[1];
  end

  // Sequencer next-state: boot countdown, run priority Halt > Stall > advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    ret_d   = ret_q;
    case (state_q)
      ST_BOOT: begin
        if (cnt_q == CNT_W'(BOOT_DELAY - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_HALT;
        end else if (!Stall) begin
          // The faulting instruction still counts as retired.
          ret_d = ret_q + XLEN'(1);
          if (target_mis) begin
            pc_d    = TRAP_VECTOR;
            mis_d   = 1'b1;
            state_d = ST_TRAP;
          end else begin
            pc_d = target;
          end
        end
      end
      ST_HALT: begin
        if (Resume) begin
          state_d = ST_RUN;
        end
      end
      ST_TRAP: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q <= (BOOT_DELAY == 0) ? ST_RUN : ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      ret_q   <= ret_d;
    end
  end

  assign PC          = pc_q;
  assign PCPlus      = pc_q + step;
  assign Valid       = (state_q == ST_RUN);
  assign Misaligned  = mis_q;
  assign RetireCount = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: two instances (32-bit aligned with
// boot delay 2, compressed with no boot delay) share one random/directed
// stimulus stream and are checked against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h100;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_TRAP = 3;

  bit          clock;
  logic        Reset, Stall, Branch, Jalr, InstrLen16, Halt, Resume;
  logic [31:0] BranchOffset, JalrBase, JalrOffset;

  logic [31:0] pc0, pcp0, rc0, pc1, pcp1, rc1;
  logic        v0, m0, v1, m1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic [31:0] ret;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Model state per instance
  int          m_mode [2];
  int          m_boot [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_ret  [2];
  logic        m_mis  [2];
  bit          known = 0;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV),
                 .COMPRESSED(0), .BOOT_DELAY(2)) dut0 (
    .clock(clock), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .BranchOffset(BranchOffset), .Jalr(Jalr), .JalrBase(JalrBase),
    .JalrOffset(JalrOffset), .InstrLen16(InstrLen16), .Halt(Halt),
    .Resume(Resume), .PC(pc0), .PCPlus(pcp0), .Valid(v0),
    .Misaligned(m0), .RetireCount(rc0));

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV),
                 .COMPRESSED(1), .BOOT_DELAY(0)) dut1 (
    .clock(clock), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .BranchOffset(BranchOffset), .Jalr(Jalr), .JalrBase(JalrBase),
    .JalrOffset(JalrOffset), .InstrLen16(InstrLen16), .Halt(Halt),
    .Resume(Resume), .PC(pc1), .PCPlus(pcp1), .Valid(v1),
    .Misaligned(m1), .RetireCount(rc1));

  always #5 clock = ~clock;

  function automatic bit comp_of(input int i);
    return (i == 1);
  endfunction

  function automatic int bd_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] got=%h expected=%h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, record expected outputs for this cycle, then
  // advance the model across the coming clock edge.
  task automatic cycle(input bit rst, input bit st, input bit br,
                       input logic [31:0] bo, input bit jl,
                       input logic [31:0] jb, input logic [31:0] jo,
                       input bit l16, input bit hl, input bit rs);
    exp_t        e;
    logic [31:0] stp, tgt;
    bit          bad;
    Reset = rst; Stall = st; Branch = br; BranchOffset = bo; Jalr = jl;
    JalrBase = jb; JalrOffset = jo; InstrLen16 = l16; Halt = hl; Resume = rs;
    for (int i = 0; i < 2; i++) begin
      stp = (comp_of(i) && l16) ? 32'd2 : 32'd4;
      if (known) begin
        e.pc     = m_pc[i];
        e.pcplus = m_pc[i] + stp;
        e.ret    = m_ret[i];
        e.valid  = (m_mode[i] == M_RUN);
        e.mis    = m_mis[i];
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
      m_mis[i] = 1'b0;
      if (!rst) begin
        m_pc[i]   = RV;
        m_ret[i]  = 32'd0;
        m_boot[i] = bd_of(i);
        m_mode[i] = (bd_of(i) == 0) ? M_RUN : M_BOOT;
      end else begin
        case (m_mode[i])
          M_BOOT: begin
            m_boot[i] = m_boot[i] - 1;
            if (m_boot[i] == 0) m_mode[i] = M_RUN;
          end
          M_RUN: begin
            if (hl) begin
              m_mode[i] = M_HALT;
            end else if (!st) begin
              m_ret[i] = m_ret[i] + 32'd1;
              if (jl)      tgt = (jb + jo) & 32'hFFFF_FFFE;
              else if (br) tgt = m_pc[i] + bo;
              else         tgt = m_pc[i] + stp;
              bad = comp_of(i) ? tgt[0] : tgt[1];
              if (bad) begin
                m_pc[i]   = TV;
                m_mis[i]  = 1'b1;
                m_mode[i] = M_TRAP;
              end else begin
                m_pc[i] = tgt;
              end
            end
          end
          M_HALT: if (rs) m_mode[i] = M_RUN;
          default: m_mode[i] = M_RUN;
        endcase
      end
    end
    known = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp(input int inst, input exp_t e, input logic [31:0] pc,
                     input logic [31:0] pcp, input logic [31:0] rc,
                     input logic v, input logic m);
    check("pc", inst, pc, e.pc);
    check("pcplus", inst, pcp, e.pcplus);
    check("retire", inst, rc, e.ret);
    check("valid", inst, {31'd0, v}, {31'd0, e.valid});
    check("misaligned", inst, {31'd0, m}, {31'd0, e.mis});
  endtask

  // Monitor: compare each presented output set against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp(0, e, pc0, pcp0, rc0, v0, m0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp(1, e, pc1, pcp1, rc1, v1, m1);
    end
  end

  function automatic logic [31:0] rnd_off();
    if ($urandom_range(0, 4) == 0) return $urandom;
    return 32'($urandom_range(0, 64)) - 32'd32;
  endfunction

  initial begin
    // Reset held two cycles, boot, then straight-line fetch.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    // Jump to 0x40, branch back by 8, jalr beats branch and clears bit 0.
    cycle(1, 0, 0, 0, 1, 32'h40, 32'h0, 0, 0, 0);
    cycle(1, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 32'h40, 1, 32'h201, 32'h0, 0, 0, 0);
    // From 0x10, branch +6: traps on the 32-bit-aligned instance.
    cycle(1, 0, 0, 0, 1, 32'h10, 32'h0, 0, 0, 0);
    cycle(1, 0, 1, 32'd6, 0, 0, 0, 0, 0, 0);
    idle(3);
    // 16-bit steps and a +2 branch.
    cycle(1, 0, 0, 0, 1, 32'h20, 32'h0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 1, 32'd2, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Stall at 0x80, then Halt+Stall, resume after 5 cycles.
    cycle(1, 0, 0, 0, 1, 32'h80, 32'h0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 1, 1, 32'h8, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cycle(1, 1, 1, 32'h8, 1, 32'h4, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    // Reset in the middle of HALT.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // Reset in the middle of TRAP (jalr to 0x12 traps on the aligned instance).
    cycle(1, 0, 0, 0, 1, 32'h12, 32'h0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // Wrap from the top of the address space.
    cycle(1, 0, 0, 0, 1, 32'hFFFF_FFF0, 32'hC, 0, 0, 0);
    idle(3);
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 79) != 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0),
            rnd_off(),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom,
            rnd_off(),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) == 0));
    end
    idle(2);
    @(negedge clock);
    #1;
    check("drain", 0, 32'(q0.size()), 32'd0);
    check("drain", 1, 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
